// File: rtl/jogador_automatico_if.sv
// Game-side link of the automatic player: LEDs and outcome flags in, start pulse and buttons out.
// The master modport is the player; the slave modport is the memory game it drives.
interface jogador_automatico_if;
   logic [3:0] leds;
   logic       pronto;
   logic       ganhou;
   logic       perdeu;
   logic       jogar;
   logic [3:0] botoes;

   modport master (input leds, pronto, ganhou, perdeu, output jogar, botoes);
   modport slave  (output leds, pronto, ganhou, perdeu, input jogar, botoes);
endinterface

// File: rtl/jogador_automatico.sv
// Automatic memory-game player: records the leds exhibition, replays it on botoes with press/gap timing.
// Optional BOT_ERRO_PROPOSITAL_EN adds injetar_erro, which rotates the last replayed entry of a round.
module jogador_automatico #(
   parameter int MAX_JOGADAS = 16,
   parameter int T_QUIET     = 20,
   parameter int T_PRESS     = 4,
   parameter int T_GAP       = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  habilitar,
`ifdef BOT_ERRO_PROPOSITAL_EN
   input  logic                  injetar_erro,
`endif
   jogador_automatico_if.master  jogo,
   output logic                  ativo,
   output logic                  erro,
   output logic [3:0]            db_contagem,
   output logic [3:0]            db_estado
);
   localparam int AW    = $clog2(MAX_JOGADAS);
   localparam int IW    = AW + 1;
   localparam int T_MAX = (T_QUIET > T_PRESS) ? ((T_QUIET > T_GAP) ? T_QUIET : T_GAP)
                                              : ((T_PRESS > T_GAP) ? T_PRESS : T_GAP);
   localparam int TW    = $clog2(T_MAX + 1);

   localparam logic [IW-1:0] CHEIO    = IW'(MAX_JOGADAS);
   localparam logic [IW-1:0] UM_I     = IW'(1);
   localparam logic [TW-1:0] UM_T     = TW'(1);
   localparam logic [TW-1:0] QUIET_M1 = TW'(T_QUIET - 1);
   localparam logic [TW-1:0] PRESS_M1 = TW'(T_PRESS - 1);
   localparam logic [TW-1:0] GAP_M1   = TW'(T_GAP - 1);

   typedef enum logic [3:0] {
      OCIOSO     = 4'd0,
      INICIA     = 4'd1,
      CAPTURA    = 4'd2,
      JOGA_PRESS = 4'd3,
      JOGA_GAP   = 4'd4,
      FIM        = 4'd5
   } estado_t;

   estado_t       estado, estado_d;
   logic [IW-1:0] contagem, contagem_d;
   logic [IW-1:0] indice, indice_d;
   logic [TW-1:0] temp, temp_d, temp_inc;
   logic [3:0]    anterior, anterior_d;
   logic [3:0]    botoes_q, botoes_d;
   logic [3:0]    entrada;
   logic          erro_d;
   logic          grava;
   logic          desfecho;
   logic          mascara;
   logic [3:0]    buffer [MAX_JOGADAS];

   assign temp_inc = (temp == '1) ? temp : temp + UM_T;
   // Outcome flags only matter once the game has actually been started.
   assign desfecho = (jogo.pronto | jogo.ganhou | jogo.perdeu)
                     && (estado != OCIOSO) && (estado != INICIA);
   assign mascara  = desfecho || !habilitar;

   always_comb begin
      estado_d   = estado;
      contagem_d = contagem;
      indice_d   = indice;
      temp_d     = temp;
      anterior_d = anterior;
      erro_d     = erro;
      grava      = 1'b0;
      botoes_d   = 4'b0;
      entrada    = 4'b0;

      case (estado)
         OCIOSO: begin
            temp_d = '0;
            if (habilitar) estado_d = INICIA;
         end
         INICIA: begin
            estado_d   = CAPTURA;
            contagem_d = '0;
            anterior_d = 4'b0;
            temp_d     = '0;
         end
         CAPTURA: begin
            anterior_d = jogo.leds;
            if (jogo.leds == 4'b0) begin
               temp_d = temp_inc;
               if (temp >= QUIET_M1 && contagem != '0) begin
                  estado_d = JOGA_PRESS;
                  indice_d = '0;
                  temp_d   = '0;
               end
            end else begin
               temp_d = '0;
               if (!$onehot(jogo.leds)) begin
                  erro_d   = 1'b1;
                  estado_d = FIM;
               end else if (jogo.leds != anterior) begin
                  if (contagem == CHEIO) begin
                     erro_d   = 1'b1;
                     estado_d = FIM;
                  end else begin
                     grava      = 1'b1;
                     contagem_d = contagem + UM_I;
                  end
               end
            end
         end
         JOGA_PRESS: begin
            if (temp == PRESS_M1) begin
               estado_d = JOGA_GAP;
               temp_d   = '0;
            end else begin
               temp_d = temp_inc;
            end
         end
         JOGA_GAP: begin
            if (temp == GAP_M1) begin
               temp_d   = '0;
               indice_d = indice + UM_I;
               if ((indice + UM_I) == contagem) begin
                  estado_d   = CAPTURA;
                  contagem_d = '0;
                  anterior_d = 4'b0;
               end else begin
                  estado_d = JOGA_PRESS;
               end
            end else begin
               temp_d = temp_inc;
            end
         end
         FIM: begin
            temp_d = '0;
         end
         default: estado_d = OCIOSO;
      endcase

      if (desfecho) begin
         estado_d = FIM;
         erro_d   = erro;
         grava    = 1'b0;
      end
      if (!habilitar) begin
         estado_d = OCIOSO;
         erro_d   = 1'b0;
         grava    = 1'b0;
         temp_d   = '0;
      end

      // The press value is latched on entry so the whole pulse stays stable.
      entrada = buffer[indice_d[AW-1:0]];
      if (estado_d == JOGA_PRESS) begin
         if (estado != JOGA_PRESS) begin
            botoes_d = entrada;
`ifdef BOT_ERRO_PROPOSITAL_EN
            if (injetar_erro && indice_d == contagem - UM_I)
               botoes_d = {entrada[2:0], entrada[3]};
`endif
         end else begin
            botoes_d = botoes_q;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado   <= OCIOSO;
         contagem <= '0;
         indice   <= '0;
         temp     <= '0;
         anterior <= 4'b0;
         botoes_q <= 4'b0;
         erro     <= 1'b0;
      end else begin
         estado   <= estado_d;
         contagem <= contagem_d;
         indice   <= indice_d;
         temp     <= temp_d;
         anterior <= anterior_d;
         botoes_q <= botoes_d;
         erro     <= erro_d;
      end
   end

   always_ff @(posedge clock) begin
      if (grava) buffer[contagem[AW-1:0]] <= jogo.leds;
   end

   assign jogo.botoes = mascara ? 4'b0 : botoes_q;
   assign jogo.jogar  = (estado == INICIA);
   assign ativo       = (estado == INICIA) || (estado == CAPTURA)
                        || (estado == JOGA_PRESS) || (estado == JOGA_GAP);
   assign db_estado   = estado;
   assign db_contagem = (estado == JOGA_PRESS || estado == JOGA_GAP) ? indice[3:0] : contagem[3:0];
endmodule
